// File: rtl/ffn_pkg.sv
// ffn_pkg: shared constants and types for the FFN result drain path
//   LAYER_W        width of the layer tag carried with each frame
//   drain_state_t  output-side state: idle (nothing buffered) or streaming lanes
package ffn_pkg;
    localparam int LAYER_W = 4;
    typedef enum logic {DRN_IDLE, DRN_STREAM} drain_state_t;
endpackage

// File: rtl/ffn_frame_fifo.sv
// ffn_frame_fifo: DEPTH-deep synchronous FIFO of WIDTH-bit frames
//   clk, rst    clock, async active-high reset (pointers only)
//   push, din   write request and frame
//   pop         read request; dout shows the head frame combinationally
//   full, empty occupancy flags; count = frames held
// A push while full is still accepted when a pop happens in the same cycle:
// the head is read out before the freed slot is overwritten at the edge.
module ffn_frame_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr;
    logic             rd;

    // Extra pointer bit separates full (same slot, different lap) from empty.
    assign empty = wptr == rptr;
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count = wptr - rptr;
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ffn_result_drain.sv
// ffn_result_drain: buffers FFN result frames and streams them lane by lane
//   clk, rst       clock, async active-high reset
//   acc_i, done_i  result frame and its one-cycle valid strobe
//   layer_i        layer tag sampled with done_i
//   res_*          valid/ready beat stream: lane value, lane index, layer, last
//   overflow_o     sticky: a frame arrived while the buffer was full
//   busy_o         buffer holds at least one frame
// All outputs come from registers through the lane mux; done_i/acc_i only
// reach them through the frame buffer.
module ffn_result_drain
    import ffn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NEURON_NUM = 4,
    parameter int FRAMES     = 2,
    parameter int RELU_EN    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH*NEURON_NUM-1:0] acc_i,
    input  logic                            done_i,
    input  logic [LAYER_W-1:0]              layer_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [DATA_WIDTH-1:0]           res_data_o,
    output logic [$clog2(NEURON_NUM)-1:0]   res_idx_o,
    output logic [LAYER_W-1:0]              res_layer_o,
    output logic                            res_last_o,
    output logic                            overflow_o,
    output logic                            busy_o
);
    localparam int ACC_W = DATA_WIDTH * NEURON_NUM;
    localparam int IW    = $clog2(NEURON_NUM);
    localparam int CW    = $clog2(FRAMES) + 1;

    typedef struct packed {
        logic [LAYER_W-1:0] layer;
        logic [ACC_W-1:0]   acc;
    } ffn_frame_t;

    ffn_frame_t        frame_in;
    ffn_frame_t        head;
    drain_state_t      state;
    drain_state_t      state_nx;
    logic [IW-1:0]     lane;
    logic [CW-1:0]     count;
    logic [DATA_WIDTH-1:0] lane_val;
    logic              full;
    logic              empty;
    logic              stream;
    logic              end_lane;
    logic              xfer;
    logic              pop;

    assign frame_in = {layer_i, acc_i};
    assign stream   = state == DRN_STREAM;
    assign end_lane = lane == IW'(NEURON_NUM - 1);
    assign xfer     = stream & res_ready_i;
    assign pop      = xfer & end_lane;
    assign busy_o   = ~empty;

    ffn_frame_fifo #(
        .WIDTH (LAYER_W + ACC_W),
        .DEPTH (FRAMES)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (done_i),
        .pop   (pop),
        .din   (frame_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Leaving STREAM only when the last frame drains with nothing arriving.
    always_comb begin
        state_nx = state;
        state_nx = (state == DRN_IDLE) ? (done_i ? DRN_STREAM : DRN_IDLE)
                 : ((pop && count == CW'(1) && !done_i) ? DRN_IDLE : DRN_STREAM);
    end

    // Outputs are forced to zero while idle so the unreset buffer never leaks.
    always_comb begin
        lane_val    = head.acc[lane*DATA_WIDTH +: DATA_WIDTH];
        res_valid_o = stream;
        res_data_o  = (!stream || (RELU_EN != 0 && lane_val[DATA_WIDTH-1])) ? '0 : lane_val;
        res_idx_o   = stream ? lane : '0;
        res_layer_o = stream ? head.layer : '0;
        res_last_o  = stream & end_lane;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DRN_IDLE;
            lane       <= '0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_nx;
            if (xfer) lane <= end_lane ? '0 : lane + 1'b1;
            if (done_i && full && !pop) overflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ffn_result_drain.sv
// tb_ffn_result_drain: self-checking bench for ffn_result_drain
//   Two instances share stimulus: dut (pass-through) and dut_r (ReLU enabled).
//   A queue-based frame model predicts every output each cycle; directed
//   tables and sequences add fixed expectations on top.
module tb_ffn_result_drain;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] acc_i = '0;
    logic        done_i = 1'b0;
    logic [3:0]  layer_i = '0;
    logic        res_ready_i = 1'b0;
    logic        res_valid_o, res_last_o, overflow_o, busy_o;
    logic [15:0] res_data_o;
    logic [1:0]  res_idx_o;
    logic [3:0]  res_layer_o;
    logic        r_valid, r_last, r_ovf, r_busy;
    logic [15:0] r_data;
    logic [1:0]  r_idx;
    logic [3:0]  r_layer;

    int n_pass = 0;
    int n_tot  = 0;

    logic [63:0] q_acc[$];
    logic [3:0]  q_ly[$];
    int          m_lane = 0;
    bit          m_ovf = 0;

    always #5 clk = ~clk;

    ffn_result_drain #(.DATA_WIDTH(16), .NEURON_NUM(4), .FRAMES(2), .RELU_EN(0)) dut (
        .clk(clk), .rst(rst), .acc_i(acc_i), .done_i(done_i), .layer_i(layer_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_idx_o(res_idx_o), .res_layer_o(res_layer_o), .res_last_o(res_last_o),
        .overflow_o(overflow_o), .busy_o(busy_o)
    );

    ffn_result_drain #(.DATA_WIDTH(16), .NEURON_NUM(4), .FRAMES(2), .RELU_EN(1)) dut_r (
        .clk(clk), .rst(rst), .acc_i(acc_i), .done_i(done_i), .layer_i(layer_i),
        .res_valid_o(r_valid), .res_ready_i(res_ready_i), .res_data_o(r_data),
        .res_idx_o(r_idx), .res_layer_o(r_layer), .res_last_o(r_last),
        .overflow_o(r_ovf), .busy_o(r_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [15:0] lane_of(input logic [63:0] a, input int k);
        return a[k*16 +: 16];
    endfunction

    function automatic void model_clear();
        q_acc.delete();
        q_ly.delete();
        m_lane = 0;
        m_ovf  = 0;
    endfunction

    // One clock edge: accept a beat if one is offered, then capture or drop.
    function automatic void model_edge(input logic d, input logic [63:0] a, input logic [3:0] l, input logic r);
        if (q_acc.size() > 0 && r) begin
            m_lane++;
            if (m_lane == 4) begin
                void'(q_acc.pop_front());
                void'(q_ly.pop_front());
                m_lane = 0;
            end
        end
        if (d) begin
            if (q_acc.size() < 2) begin
                q_acc.push_back(a);
                q_ly.push_back(l);
            end else m_ovf = 1;
        end
    endfunction

    task automatic check_all();
        bit          v = q_acc.size() > 0;
        logic [15:0] d = v ? lane_of(q_acc[0], m_lane) : 16'h0;
        chk("valid",    res_valid_o, v);
        chk("data",     res_data_o, d);
        chk("idx",      res_idx_o, v ? m_lane : 0);
        chk("layer",    res_layer_o, v ? q_ly[0] : 4'h0);
        chk("last",     res_last_o, v && m_lane == 3);
        chk("overflow", overflow_o, m_ovf);
        chk("busy",     busy_o, v);
        chk("r_valid",  r_valid, v);
        chk("r_data",   r_data, d[15] ? 16'h0 : d);
        chk("r_idx",    r_idx, v ? m_lane : 0);
        chk("r_last",   r_last, v && m_lane == 3);
        chk("r_ovf",    r_ovf, m_ovf);
    endtask

    task automatic step(input logic d, input logic [63:0] a, input logic [3:0] l, input logic r);
        done_i = d;
        acc_i = a;
        layer_i = l;
        res_ready_i = r;
        @(posedge clk);
        model_edge(d, a, l, r);
        @(negedge clk);
        done_i = 1'b0;
        check_all();
    endtask

    // Asserted between edges so the asynchronous clear is observed at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 model_clear();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        res_ready_i = 1'b0;
        check_all();
    endtask

    typedef struct {
        logic        done;
        logic [63:0] acc;
        logic [3:0]  layer;
        logic        ready;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  ei;
        logic        el;
        logic [3:0]  ely;
    } vec_t;

    localparam logic [63:0] F1 = {16'hFFFE, 16'h0007, 16'h0000, 16'h0005};
    localparam logic [63:0] FR = {16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};

    initial begin
        vec_t        tbl[14];
        logic [15:0] relu_exp[4];
        logic [15:0] raw_exp[4];
        tbl[0]  = '{1'b1, F1,    4'd3, 1'b1, 1'b1, 16'h0005, 2'd0, 1'b0, 4'd3};
        tbl[1]  = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 16'h0000, 2'd1, 1'b0, 4'd3};
        tbl[2]  = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 16'h0007, 2'd2, 1'b0, 4'd3};
        tbl[3]  = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 16'hFFFE, 2'd3, 1'b1, 4'd3};
        tbl[4]  = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, F1,    4'd5, 1'b0, 1'b1, 16'h0005, 2'd0, 1'b0, 4'd5};
        tbl[6]  = '{1'b0, 64'h0, 4'd0, 1'b0, 1'b1, 16'h0005, 2'd0, 1'b0, 4'd5};
        tbl[7]  = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 16'h0000, 2'd1, 1'b0, 4'd5};
        tbl[8]  = '{1'b0, 64'h0, 4'd0, 1'b0, 1'b1, 16'h0000, 2'd1, 1'b0, 4'd5};
        tbl[9]  = '{1'b0, 64'h0, 4'd0, 1'b0, 1'b1, 16'h0000, 2'd1, 1'b0, 4'd5};
        tbl[10] = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 16'h0007, 2'd2, 1'b0, 4'd5};
        tbl[11] = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b1, 16'hFFFE, 2'd3, 1'b1, 4'd5};
        tbl[12] = '{1'b0, 64'h0, 4'd0, 1'b0, 1'b1, 16'hFFFE, 2'd3, 1'b1, 4'd5};
        tbl[13] = '{1'b0, 64'h0, 4'd0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 4'd0};
        relu_exp = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0000};
        raw_exp  = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};

        model_clear();
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst = 1'b0;
        check_all();

        // single frame, then the same frame under backpressure
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].done, tbl[i].acc, tbl[i].layer, tbl[i].ready);
            chk("tbl_valid", res_valid_o, tbl[i].ev);
            chk("tbl_data",  res_data_o,  tbl[i].ed);
            chk("tbl_idx",   res_idx_o,   tbl[i].ei);
            chk("tbl_last",  res_last_o,  tbl[i].el);
            chk("tbl_layer", res_layer_o, tbl[i].ely);
        end

        // back-to-back frames two cycles apart: eight beats with no bubble
        step(1'b1, 64'h0004_0003_0002_0001, 4'd1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("b2b_valid", res_valid_o, 1'b1);
            chk("b2b_layer", res_layer_o, (k < 4) ? 4'd1 : 4'd2);
            chk("b2b_idx",   res_idx_o, k % 4);
            step(k == 1, 64'h0014_0013_0012_0011, 4'd2, 1'b1);
        end
        chk("b2b_done", res_valid_o, 1'b0);

        // third frame into a full buffer is dropped
        step(1'b1, 64'h1111_2222_3333_4444, 4'd6, 1'b0);
        step(1'b1, 64'h5555_6666_7777_8888, 4'd7, 1'b0);
        step(1'b1, 64'h9999_AAAA_BBBB_CCCC, 4'd8, 1'b0);
        chk("ovf_set", overflow_o, 1'b1);
        for (int k = 0; k < 9; k++) begin
            chk("ovf_drop", res_valid_o && res_layer_o == 4'd8, 1'b0);
            step(1'b0, 64'h0, 4'd0, 1'b1);
        end
        chk("ovf_sticky", overflow_o, 1'b1);

        // pop of the last head beat and a new frame in the same cycle while full
        do_reset();
        step(1'b1, 64'h1111_2222_3333_4444, 4'd6, 1'b0);
        step(1'b1, 64'h5555_6666_7777_8888, 4'd7, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 64'h0, 4'd0, 1'b1);
        chk("simul_last", res_last_o, 1'b1);
        step(1'b1, 64'hDDDD_EEEE_FFFF_0123, 4'd9, 1'b1);
        chk("simul_no_ovf", overflow_o, 1'b0);
        chk("simul_next", res_layer_o, 4'd7);
        for (int k = 0; k < 8; k++) step(1'b0, 64'h0, 4'd0, 1'b1);

        // ReLU clamps negative lanes only
        step(1'b1, FR, 4'd4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("relu_out", r_data, relu_exp[k]);
            chk("relu_raw", res_data_o, raw_exp[k]);
            step(1'b0, 64'h0, 4'd0, 1'b1);
        end

        // reset in the middle of a frame, then a fresh frame from lane 0
        step(1'b1, 64'h0044_0033_0022_0011, 4'd5, 1'b1);
        step(1'b0, 64'h0, 4'd0, 1'b1);
        step(1'b0, 64'h0, 4'd0, 1'b1);
        chk("mid_lane", res_idx_o, 2'd2);
        do_reset();
        chk("rst_busy", busy_o, 1'b0);
        step(1'b1, 64'h0404_0303_0202_0101, 4'd10, 1'b1);
        chk("rst_restart_idx", res_idx_o, 2'd0);
        chk("rst_restart_data", res_data_o, 16'h0101);

        // random traffic against the frame model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                 (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
